// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT schedule controller: sequences butterflies over all stages.
// Optional macro FFT_CTRL_TIMEOUT_EN adds a bf_done watchdog of TIMEOUT cycles in WAIT.
module fft_ctrl #(
  parameter int unsigned LOG2N   = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       bf_str,
  input  logic                       bf_done,
  input  logic                       bf_error,
  output logic [LOG2N-1:0]           rd_addr0,
  output logic [LOG2N-1:0]           rd_addr1,
  output logic [LOG2N-2:0]           tw_addr,
  output logic                       wr_en,
  output logic [$clog2(LOG2N)-1:0]   stage
);

  localparam int unsigned NB = LOG2N - 1;
  localparam int unsigned SW = $clog2(LOG2N);
  localparam logic [NB-1:0] B_LAST     = '1;
  localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2N - 1);

  if (LOG2N < 2 || LOG2N > 10 || TIMEOUT < 1) begin : g_bad_param
    $error("fft_ctrl: illegal LOG2N or TIMEOUT");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, NEXT, FIN} state_t;

  state_t          state, state_nxt;
  logic [NB-1:0]   b, b_nxt;
  logic [SW-1:0]   stage_nxt;
  logic            err_nxt;
  logic [LOG2N-1:0] bx, mask, pos, a0, a1;
  logic [LOG2N-2:0] tw_nxt;
  logic [SW-1:0]    tsh;

`ifdef FFT_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt, cnt_nxt;
`endif

  // Next-state, butterfly/stage counters and sticky error
  always_comb begin
    state_nxt = state;
    b_nxt     = b;
    stage_nxt = stage;
    err_nxt   = error;
`ifdef FFT_CTRL_TIMEOUT_EN
    cnt_nxt   = '0;
`endif
    case (state)
      IDLE: if (start) begin
        state_nxt = ISSUE;
        b_nxt     = '0;
        stage_nxt = '0;
        err_nxt   = 1'b0;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bf_done) begin
          state_nxt = WRITE;
          if (bf_error) err_nxt = 1'b1;
        end
`ifdef FFT_CTRL_TIMEOUT_EN
        else if (cnt == TW'(TIMEOUT - 1)) begin
          state_nxt = FIN;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
`endif
      end
      WRITE: state_nxt = NEXT;
      NEXT: begin
        if (stage == STAGE_LAST && b == B_LAST) begin
          state_nxt = FIN;
        end else begin
          state_nxt = ISSUE;
          b_nxt     = b + NB'(1);
          if (b == B_LAST) stage_nxt = stage + SW'(1);
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address generation: insert a zero bit at position stage into b
  always_comb begin
    bx     = LOG2N'(b_nxt);
    mask   = (LOG2N'(1) << stage_nxt) - LOG2N'(1);
    pos    = bx & mask;
    a0     = (((bx >> stage_nxt) << stage_nxt) << 1) | pos;
    a1     = a0 | (LOG2N'(1) << stage_nxt);
    tsh    = STAGE_LAST - stage_nxt;
    tw_nxt = (LOG2N-1)'(pos << tsh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      b        <= '0;
      stage    <= '0;
      error    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bf_str   <= 1'b0;
      wr_en    <= 1'b0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
      tw_addr  <= '0;
    end else begin
      state  <= state_nxt;
      b      <= b_nxt;
      stage  <= stage_nxt;
      error  <= err_nxt;
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == FIN);
      bf_str <= (state_nxt == ISSUE);
      wr_en  <= (state_nxt == WRITE);
      if (state_nxt == ISSUE) begin
        rd_addr0 <= a0;
        rd_addr1 <= a1;
        tw_addr  <= tw_nxt;
      end
    end
  end

`ifdef FFT_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl (LOG2N=3): schedule model, butterfly responder, directed scenarios.
module tb_fft_ctrl;
  localparam int unsigned LOG2N = 3;
  localparam int NBF = LOG2N * (1 << (LOG2N - 1));

  logic clk = 1'b0;
  logic rst_n, start, busy, done, error, bf_str, bf_done, bf_error, wr_en;
  logic [LOG2N-1:0] rd_addr0, rd_addr1;
  logic [LOG2N-2:0] tw_addr;
  logic [1:0] stage;

  fft_ctrl #(.LOG2N(LOG2N), .TIMEOUT(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .bf_str(bf_str), .bf_done(bf_done), .bf_error(bf_error), .rd_addr0(rd_addr0),
    .rd_addr1(rd_addr1), .tw_addr(tw_addr), .wr_en(wr_en), .stage(stage)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  int iss_cnt, wr_cnt, done_cnt, busy_gap, done_cyc, start_cyc;
  int issue_n, cd, err_at, poke_at, hold_at;
  bit err_sent, xfer_on, poke;

  // Schedule model from the arithmetic definition, plus the literal table it must reproduce
  int m_a0 [NBF], m_a1 [NBF], m_tw [NBF], m_st [NBF];
  int lit_a0 [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int lit_a1 [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int lit_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Butterfly unit stand-in: bf_done four cycles after each bf_str
  always @(negedge clk) begin
    bf_done = 1'b0;
    bf_error = 1'b0;
    if (poke) begin start = 1'b0; poke = 1'b0; end
    if (!rst_n) cd = 0;
    else begin
      if (cd > 0) begin
        cd--;
        if (cd == 2 && issue_n == poke_at) begin start = 1'b1; poke = 1'b1; end
        if (cd == 0) begin
          bf_done = 1'b1;
          if (issue_n == err_at) begin bf_error = 1'b1; err_sent = 1'b1; end
        end
      end
      if (bf_str) begin
        issue_n++;
        if (issue_n != hold_at) cd = 4;
      end
    end
  end

  // Compare process: every issue and write against the model
  always @(negedge clk) if (rst_n) begin
    if (bf_str) begin
      if (iss_cnt < NBF) begin
        chk($sformatf("iss%0d_a0", iss_cnt), int'(rd_addr0), m_a0[iss_cnt]);
        chk($sformatf("iss%0d_a1", iss_cnt), int'(rd_addr1), m_a1[iss_cnt]);
        chk($sformatf("iss%0d_tw", iss_cnt), int'(tw_addr), m_tw[iss_cnt]);
        chk($sformatf("iss%0d_stage", iss_cnt), int'(stage), m_st[iss_cnt]);
      end else chk("extra_bf_str", iss_cnt, NBF - 1);
      iss_cnt++;
    end
    if (wr_en) begin
      if (wr_cnt < NBF) begin
        chk($sformatf("wr%0d_a0", wr_cnt), int'(rd_addr0), m_a0[wr_cnt]);
        chk($sformatf("wr%0d_a1", wr_cnt), int'(rd_addr1), m_a1[wr_cnt]);
        chk($sformatf("wr%0d_tw", wr_cnt), int'(tw_addr), m_tw[wr_cnt]);
        chk($sformatf("wr%0d_err", wr_cnt), int'(error), int'(err_sent));
      end else chk("extra_wr_en", wr_cnt, NBF - 1);
      wr_cnt++;
    end
    if (xfer_on && !busy) busy_gap++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      xfer_on = 1'b0;
    end
  end

  task automatic clear_run(input int e, input int p, input int h);
    iss_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_gap = 0; issue_n = 0;
    err_sent = 1'b0; err_at = e; poke_at = p; hold_at = h;
  endtask

  task automatic kick();
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    xfer_on = 1'b1;
    chk("issue_busy", int'(busy), 1);
    chk("issue_bf_str", int'(bf_str), 1);
    chk("issue_err_clr", int'(error), 0);
  endtask

  task automatic run_xfer(input int e, input int p, input int h);
    @(negedge clk);
    clear_run(e, p, h);
    kick();
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_full(input string tag, input int exp_err);
    chk({tag, "_wr"}, wr_cnt, 12);
    chk({tag, "_iss"}, iss_cnt, 12);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_cycles"}, done_cyc - start_cyc + 1, 12 * (3 + 4) + 2);
    chk({tag, "_busy_gap"}, busy_gap, 0);
    chk({tag, "_idle"}, int'(busy), 0);
    chk({tag, "_error"}, int'(error), exp_err);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, int'({busy, done, error, bf_str, wr_en}), 0);
    chk({tag, "_addr"}, int'({rd_addr0, rd_addr1, tw_addr, stage}), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bf_done = 1'b0; bf_error = 1'b0;
    cd = 0; poke = 1'b0; xfer_on = 1'b0;
    clear_run(0, 0, 0);
    for (int s = 0; s < LOG2N; s++)
      for (int b = 0; b < (1 << (LOG2N - 1)); b++) begin
        int k, span, p;
        k = s * (1 << (LOG2N - 1)) + b;
        span = 1 << s;
        p = b % span;
        m_a0[k] = (b / span) * 2 * span + p;
        m_a1[k] = m_a0[k] + span;
        m_tw[k] = p * (1 << (LOG2N - 1 - s));
        m_st[k] = s;
      end
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("model_a0_%0d", k), m_a0[k], lit_a0[k]);
      chk($sformatf("model_a1_%0d", k), m_a1[k], lit_a1[k]);
      chk($sformatf("model_tw_%0d", k), m_tw[k], lit_tw[k]);
    end

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(0, 0, 0);
    check_full("basic", 0);

    run_xfer(0, 5, 0);
    check_full("start_ignored", 0);

    run_xfer(2, 0, 0);
    check_full("bf_err", 1);
    repeat (5) @(negedge clk);
    chk("err_sticky", int'(error), 1);

    run_xfer(0, 0, 0);
    check_full("err_cleared", 0);

    // Reset during the first stage-1 butterfly's WAIT
    @(negedge clk);
    clear_run(0, 0, 0);
    kick();
    for (int i = 0; i < 200 && iss_cnt < 5; i++) @(negedge clk);
    chk("reach_stage1", iss_cnt, 5);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    xfer_on = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_reset_no_done", done_cnt, 0);
    chk("mid_reset_wr", wr_cnt, 4);
    rst_n = 1'b1;
    @(negedge clk);
    run_xfer(0, 0, 0);
    check_full("after_reset", 0);

`ifdef FFT_CTRL_TIMEOUT_EN
    run_xfer(0, 0, 3);
    chk("to_wr", wr_cnt, 2);
    chk("to_done", done_cnt, 1);
    chk("to_error", int'(error), 1);
    chk("to_idle", int'(busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
